// File: rtl/wb_queue_if.sv
// Bundle of the wb_queue producer handshake, register-file write port,
// forwarding lookups and occupancy status.
interface wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              port_busy;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              write;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  count;
  logic              empty;

  modport master (
    output in_valid, in_reg, in_data, port_busy, readReg1, readReg2,
    input  in_ready, writeReg, writeData, write,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty
  );

  modport slave (
    input  in_valid, in_reg, in_data, port_busy, readReg1, readReg2,
    output in_ready, writeReg, writeData, write,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register file write port, with
// combinational read-side forwarding of every pending write.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  wb_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] wreg_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic push_fire;
  logic store;
  logic pop;

  assign bus.in_ready = !reset && (count_reg < CNT_W'(DEPTH));
  assign push_fire    = bus.in_valid && bus.in_ready;
  // Register 0 is hard-wired: the handshake completes but nothing is queued.
  assign store        = push_fire && (bus.in_reg != '0);
  assign pop          = (count_reg != '0) && !bus.port_busy;

  always_ff @(posedge clk) begin
    if (store) begin
      reg_mem[tail_reg]  <= bus.in_reg;
      data_mem[tail_reg] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      write_reg <= 1'b0;
      wreg_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      write_reg <= pop;
      if (store) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg  <= head_reg + PTR_W'(1);
        wreg_reg  <= reg_mem[head_reg];
        wdata_reg <= data_mem[head_reg];
      end
      case ({store, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign bus.writeReg  = wreg_reg;
  assign bus.writeData = wdata_reg;
  assign bus.write     = write_reg;
  assign bus.count     = count_reg;
  assign bus.empty     = (count_reg == '0) && !write_reg;

  // Slot gi is the gi-th oldest live entry counting from head.
  logic [PTR_W-1:0] slot_idx  [DEPTH];
  logic             slot_live [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_idx[gi]  = head_reg + PTR_W'(gi);
    assign slot_live[gi] = CNT_W'(gi) < count_reg;
  end

  logic [ADDR_W-1:0] rd_addr  [2];
  logic              fwd_hit  [2];
  logic [DATA_W-1:0] fwd_data [2];

  assign rd_addr[0] = bus.readReg1;
  assign rd_addr[1] = bus.readReg2;

  for (genvar gp = 0; gp < 2; gp++) begin : g_fwd
    // Scan oldest to youngest so the last match wins.
    always_comb begin
      fwd_hit[gp]  = 1'b0;
      fwd_data[gp] = '0;
      if (write_reg && (wreg_reg == rd_addr[gp])) begin
        fwd_hit[gp]  = 1'b1;
        fwd_data[gp] = wdata_reg;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_live[i] && (reg_mem[slot_idx[i]] == rd_addr[gp])) begin
          fwd_hit[gp]  = 1'b1;
          fwd_data[gp] = data_mem[slot_idx[i]];
        end
      end
      if (rd_addr[gp] == '0) begin
        fwd_hit[gp]  = 1'b0;
        fwd_data[gp] = '0;
      end
    end
  end

  assign bus.fwd_hit1  = fwd_hit[0];
  assign bus.fwd_hit2  = fwd_hit[1];
  assign bus.fwd_data1 = fwd_data[0];
  assign bus.fwd_data2 = fwd_data[1];
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_write;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        busy;
    logic [4:0]  r1;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_write;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
    logic        e_empty;
    logic        e_hit1;
    logic [31:0] e_fdata1;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(logic rst, logic v, logic [4:0] rg, logic [31:0] d,
                              logic busy, logic [4:0] r1, logic er, logic [2:0] ec,
                              logic ew, logic [4:0] ewr, logic [31:0] ewd,
                              logic ee, logic eh, logic [31:0] ef);
    vec_t t;
    t.rst = rst; t.v = v; t.rg = rg; t.d = d; t.busy = busy; t.r1 = r1;
    t.e_ready = er; t.e_count = ec; t.e_write = ew; t.e_wreg = ewr;
    t.e_wdata = ewd; t.e_empty = ee; t.e_hit1 = eh; t.e_fdata1 = ef;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [4:0] rg,
                       input logic [31:0] d, input logic busy,
                       input logic [4:0] r1, input logic [4:0] r2);
    reset         = rst;
    bus.in_valid  = v;
    bus.in_reg    = rg;
    bus.in_data   = d;
    bus.port_busy = busy;
    bus.readReg1  = r1;
    bus.readReg2  = r2;
  endtask

  // Youngest pending value for an address; output stage is the oldest candidate.
  task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (a != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].r == a) begin
          hit  = 1'b1;
          data = mq[i].d;
        end
      end
      if (!hit && m_write && m_wreg == a) begin
        hit  = 1'b1;
        data = m_wdata;
      end
    end
  endtask

  task automatic model_step();
    logic room;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_write = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
    end else begin
      room = mq.size() < DEPTH;
      if (mq.size() > 0 && !bus.port_busy) begin
        e       = mq.pop_front();
        m_write = 1'b1;
        m_wreg  = e.r;
        m_wdata = e.d;
      end else begin
        m_write = 1'b0;
      end
      if (bus.in_valid && room && bus.in_reg != 0) begin
        e.r = bus.in_reg;
        e.d = bus.in_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    logic        h;
    logic [31:0] fd;
    chk("in_ready", 64'(bus.in_ready), 64'(!reset && mq.size() < DEPTH));
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("empty", 64'(bus.empty), 64'(mq.size() == 0 && !m_write));
    chk("write", 64'(bus.write), 64'(m_write));
    chk("writeReg", 64'(bus.writeReg), 64'(m_wreg));
    chk("writeData", 64'(bus.writeData), 64'(m_wdata));
    model_fwd(bus.readReg1, h, fd);
    chk("fwd_hit1", 64'(bus.fwd_hit1), 64'(h));
    chk("fwd_data1", 64'(bus.fwd_data1), 64'(fd));
    model_fwd(bus.readReg2, h, fd);
    chk("fwd_hit2", 64'(bus.fwd_hit2), 64'(h));
    chk("fwd_data2", 64'(bus.fwd_data2), 64'(fd));
  endtask

  task automatic to_negedge();
    @(negedge clk);
    check_model();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_cycle();
    to_negedge();
    finish_cycle();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    vt[0]  = mk(0,1,3,32'hDEADBEEF,0,3,  1,0,0,0,32'h0,1,        0,32'h0);
    vt[1]  = mk(0,0,0,32'h0,0,3,         1,1,0,0,32'h0,0,        1,32'hDEADBEEF);
    vt[2]  = mk(0,0,0,32'h0,0,3,         1,0,1,3,32'hDEADBEEF,0, 1,32'hDEADBEEF);
    vt[3]  = mk(0,0,0,32'h0,0,3,         1,0,0,3,32'hDEADBEEF,1, 0,32'h0);
    vt[4]  = mk(0,1,1,32'h101,1,1,       1,0,0,3,32'hDEADBEEF,1, 0,32'h0);
    vt[5]  = mk(0,1,2,32'h102,1,1,       1,1,0,3,32'hDEADBEEF,0, 1,32'h101);
    vt[6]  = mk(0,1,3,32'h103,1,1,       1,2,0,3,32'hDEADBEEF,0, 1,32'h101);
    vt[7]  = mk(0,1,4,32'h104,1,1,       1,3,0,3,32'hDEADBEEF,0, 1,32'h101);
    vt[8]  = mk(0,1,5,32'h105,1,4,       0,4,0,3,32'hDEADBEEF,0, 1,32'h104);
    vt[9]  = mk(0,0,0,32'h0,0,5,         0,4,0,3,32'hDEADBEEF,0, 0,32'h0);
    vt[10] = mk(0,0,0,32'h0,0,1,         1,3,1,1,32'h101,0,      1,32'h101);
    vt[11] = mk(0,0,0,32'h0,0,1,         1,2,1,2,32'h102,0,      0,32'h0);
    vt[12] = mk(0,0,0,32'h0,0,0,         1,1,1,3,32'h103,0,      0,32'h0);
    vt[13] = mk(0,0,0,32'h0,0,0,         1,0,1,4,32'h104,0,      0,32'h0);
    vt[14] = mk(0,0,0,32'h0,0,0,         1,0,0,4,32'h104,1,      0,32'h0);
    vt[15] = mk(0,1,8,32'h208,1,0,       1,0,0,4,32'h104,1,      0,32'h0);
    vt[16] = mk(0,1,9,32'h209,1,0,       1,1,0,4,32'h104,0,      0,32'h0);
    vt[17] = mk(0,1,10,32'h20A,1,0,      1,2,0,4,32'h104,0,      0,32'h0);
    vt[18] = mk(0,1,11,32'h20B,1,0,      1,3,0,4,32'h104,0,      0,32'h0);
    vt[19] = mk(0,1,12,32'h20C,0,12,     0,4,0,4,32'h104,0,      0,32'h0);
    vt[20] = mk(0,1,12,32'h20C,0,12,     1,3,1,8,32'h208,0,      0,32'h0);
    vt[21] = mk(0,0,0,32'h0,0,12,        1,3,1,9,32'h209,0,      1,32'h20C);

    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    finish_cycle();
    finish_cycle();

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].v, vt[i].rg, vt[i].d, vt[i].busy, vt[i].r1, 5'd0);
      to_negedge();
      chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vt[i].e_ready));
      chk($sformatf("vec%0d.count", i), 64'(bus.count), 64'(vt[i].e_count));
      chk($sformatf("vec%0d.write", i), 64'(bus.write), 64'(vt[i].e_write));
      chk($sformatf("vec%0d.writeReg", i), 64'(bus.writeReg), 64'(vt[i].e_wreg));
      chk($sformatf("vec%0d.writeData", i), 64'(bus.writeData), 64'(vt[i].e_wdata));
      chk($sformatf("vec%0d.empty", i), 64'(bus.empty), 64'(vt[i].e_empty));
      chk($sformatf("vec%0d.fwd_hit1", i), 64'(bus.fwd_hit1), 64'(vt[i].e_hit1));
      chk($sformatf("vec%0d.fwd_data1", i), 64'(bus.fwd_data1), 64'(vt[i].e_fdata1));
      $display("vec %0d: v=%0b reg=%0d busy=%0b -> write=%0b wreg=%0d count=%0d",
               i, vt[i].v, vt[i].rg, vt[i].busy, bus.write, bus.writeReg, bus.count);
      finish_cycle();
    end
    idle(6);

    // Forwarding priority: two queued writes to the same register.
    drive(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 5'd0);
    run_cycle();
    drive(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 5'd0);
    run_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0);
    to_negedge();
    chk("prio.fwd_hit1", 64'(bus.fwd_hit1), 64'd1);
    chk("prio.fwd_data1", 64'(bus.fwd_data1), 64'h22);
    chk("prio.fwd_hit2", 64'(bus.fwd_hit2), 64'd0);
    chk("prio.fwd_data2", 64'(bus.fwd_data2), 64'd0);
    $display("prio: hit1=%0b data1=%0h hit2=%0b", bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2);
    finish_cycle();
    idle(5);

    // Register 0 writes are acknowledged and discarded.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    to_negedge();
    chk("r0.in_ready", 64'(bus.in_ready), 64'd1);
    finish_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      to_negedge();
      chk("r0.count", 64'(bus.count), 64'd0);
      chk("r0.write", 64'(bus.write), 64'd0);
      $display("r0 cycle %0d: count=%0d write=%0b", i, bus.count, bus.write);
      finish_cycle();
    end

    // Reset while draining.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 5'(i + 16), 32'(i * 3), 1'b1, 5'd0, 5'd0);
      run_cycle();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd17, 5'd0);
    run_cycle();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd17, 5'd0);
    to_negedge();
    chk("rst.pre_write", 64'(bus.write), 64'd1);
    chk("rst.pre_count", 64'(bus.count), 64'd3);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
    finish_cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd17, 5'd0);
    for (int i = 0; i < 4; i++) begin
      to_negedge();
      chk("rst.write", 64'(bus.write), 64'd0);
      chk("rst.count", 64'(bus.count), 64'd0);
      chk("rst.empty", 64'(bus.empty), 64'd1);
      chk("rst.fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
      $display("rst cycle %0d: write=%0b count=%0d empty=%0b", i, bus.write, bus.count, bus.empty);
      finish_cycle();
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      to_negedge();
      if (i % 100 == 0)
        $display("rand %0d: count=%0d write=%0b wreg=%0d", i, bus.count, bus.write, bus.writeReg);
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
